nanorv32_rf_wb_ctrl: RTL and testbench

Write-back controller for the NANORV32 register file: it collects results from the ALU (single-cycle) and the load/store unit (variable latency), and drives the regfile's two write ports (`sel_rd`/`rd`/`write_rd` and `sel_rd2`/`rd2`/`write_rd2`). It also keeps a per-register pending-load scoreboard that produces a decode stall, and a same-cycle forwarding path for the regfile read ports. It sits between the execute/LSU stages and `nanorv32_regfile`.

---
 rtl/nanorv32_rf_wb_ctrl_pkg.sv | 22 ++
 rtl/nanorv32_rf_wb_ctrl_if.sv | 47 ++++
 rtl/nanorv32_wb_fifo.sv | 44 ++++
 rtl/nanorv32_rf_wb_ctrl.sv | 96 +++++++++
 tb/tb_nanorv32_rf_wb_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nanorv32_rf_wb_ctrl_pkg.sv
// Shared constants, types and helpers for the NANORV32 register-file write-back controller.
package nanorv32_rf_wb_ctrl_pkg;

  localparam int NANORV32_RF_PORTRD_MSB = 4;
  localparam int NANORV32_DATA_MSB      = 31;
  localparam int NANORV32_RF_NUM_REGS   = 32;

  typedef logic [NANORV32_RF_PORTRD_MSB:0] reg_sel_t;
  typedef logic [NANORV32_DATA_MSB:0]      data_t;
  typedef logic [NANORV32_RF_NUM_REGS-1:0] reg_mask_t;

  typedef struct packed {
    reg_sel_t rd;
    data_t    data;
  } lq_entry_t;

  // x0 only behaves as a real register in micro-ROM mode
  function automatic logic writable(input reg_sel_t sel, input logic hidden);
    return (sel != '0) || hidden;
  endfunction

endpackage

// File: rtl/nanorv32_rf_wb_ctrl_if.sv
// Bundles the result, decode and regfile write-port signals of the write-back controller.
interface nanorv32_rf_wb_ctrl_if;
  import nanorv32_rf_wb_ctrl_pkg::*;

  logic     allow_hidden_use_of_x0;
  logic     alu_valid;
  reg_sel_t alu_sel_rd;
  data_t    alu_data;
  logic     lsu_valid;
  reg_sel_t lsu_sel_rd;
  data_t    lsu_data;
  logic     lsu_ready;
  logic     ld_issue_valid;
  reg_sel_t ld_issue_rd;
  reg_sel_t dec_rs1;
  reg_sel_t dec_rs2;
  reg_sel_t dec_rd;
  logic     dec_valid;
  logic     dec_stall;
  reg_sel_t sel_rd;
  data_t    rd;
  logic     write_rd;
  reg_sel_t sel_rd2;
  data_t    rd2;
  logic     write_rd2;
  logic     fwd_a_valid;
  data_t    fwd_a_data;
  logic     fwd_b_valid;
  data_t    fwd_b_data;

  modport master (
    output allow_hidden_use_of_x0, alu_valid, alu_sel_rd, alu_data,
           lsu_valid, lsu_sel_rd, lsu_data, ld_issue_valid, ld_issue_rd,
           dec_rs1, dec_rs2, dec_rd, dec_valid,
    input  lsu_ready, dec_stall, sel_rd, rd, write_rd, sel_rd2, rd2, write_rd2,
           fwd_a_valid, fwd_a_data, fwd_b_valid, fwd_b_data
  );

  modport slave (
    input  allow_hidden_use_of_x0, alu_valid, alu_sel_rd, alu_data,
           lsu_valid, lsu_sel_rd, lsu_data, ld_issue_valid, ld_issue_rd,
           dec_rs1, dec_rs2, dec_rd, dec_valid,
    output lsu_ready, dec_stall, sel_rd, rd, write_rd, sel_rd2, rd2, write_rd2,
           fwd_a_valid, fwd_a_data, fwd_b_valid, fwd_b_data
  );

endinterface

// File: rtl/nanorv32_wb_fifo.sv
// Generic synchronous FIFO; pointers carry an extra wrap bit to tell full from empty.
module nanorv32_wb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign dout  = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full)
        wptr <= wptr + (AW+1)'(1);
      if (pop && !empty)
        rptr <= rptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset; the pointers alone define what is valid
  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/nanorv32_rf_wb_ctrl.sv
// Write-back controller: ALU pass-through on port 1, queued load results on port 2,
// pending-load scoreboard for decode stalls and same-cycle forwarding.
module nanorv32_rf_wb_ctrl #(
  parameter int LQ_DEPTH = 2
) (
  input logic                 clk,
  input logic                 rst,
  nanorv32_rf_wb_ctrl_if.slave bus
);
  import nanorv32_rf_wb_ctrl_pkg::*;

  lq_entry_t push_entry;
  lq_entry_t head;
  logic      lq_full;
  logic      lq_empty;
  logic      lq_push;
  logic      collision;
  logic      hidden;
  reg_mask_t pend;
  reg_mask_t pend_set;
  reg_mask_t pend_clr;
  logic      hz_rs1;
  logic      hz_rs2;
  logic      hz_rd;

  assign hidden = bus.allow_hidden_use_of_x0;

  assign bus.write_rd = bus.alu_valid && writable(bus.alu_sel_rd, hidden);
  assign bus.sel_rd   = bus.alu_sel_rd;
  assign bus.rd       = bus.alu_data;

  // Loads to a non-writable register are acknowledged but never enter the queue
  assign bus.lsu_ready = !lq_full;
  assign lq_push       = bus.lsu_valid && !lq_full && writable(bus.lsu_sel_rd, hidden);
  assign push_entry    = '{rd: bus.lsu_sel_rd, data: bus.lsu_data};

  nanorv32_wb_fifo #(
    .WIDTH($bits(lq_entry_t)),
    .DEPTH(LQ_DEPTH)
  ) u_lq (
    .clk  (clk),
    .rst  (rst),
    .push (lq_push),
    .pop  (bus.write_rd2),
    .din  (push_entry),
    .dout (head),
    .full (lq_full),
    .empty(lq_empty)
  );

  // Port 1 wins a same-register collision; the head simply waits a cycle
  assign collision     = bus.write_rd && (bus.alu_sel_rd == head.rd);
  assign bus.write_rd2 = !lq_empty && !collision;
  assign bus.sel_rd2   = lq_empty ? '0 : head.rd;
  assign bus.rd2       = lq_empty ? '0 : head.data;

  assign pend_set = (bus.ld_issue_valid && writable(bus.ld_issue_rd, hidden))
                    ? (reg_mask_t'(1) << bus.ld_issue_rd) : '0;
  assign pend_clr = bus.write_rd2 ? (reg_mask_t'(1) << head.rd) : '0;

  // Set is applied after clear so a re-issued load keeps its register pending
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pend <= '0;
    else
      pend <= (pend & ~pend_clr) | pend_set;
  end

  assign hz_rs1        = pend[bus.dec_rs1] && writable(bus.dec_rs1, hidden);
  assign hz_rs2        = pend[bus.dec_rs2] && writable(bus.dec_rs2, hidden);
  assign hz_rd         = pend[bus.dec_rd]  && writable(bus.dec_rd, hidden);
  assign bus.dec_stall = bus.dec_valid && (hz_rs1 || hz_rs2 || hz_rd);

  // Forwarding mirrors the regfile: port 1 has priority over port 2
  always_comb begin
    bus.fwd_a_valid = 1'b0;
    bus.fwd_a_data  = '0;
    bus.fwd_b_valid = 1'b0;
    bus.fwd_b_data  = '0;
    if (bus.write_rd && bus.alu_sel_rd == bus.dec_rs1) begin
      bus.fwd_a_valid = 1'b1;
      bus.fwd_a_data  = bus.alu_data;
    end else if (bus.write_rd2 && bus.sel_rd2 == bus.dec_rs1) begin
      bus.fwd_a_valid = 1'b1;
      bus.fwd_a_data  = bus.rd2;
    end
    if (bus.write_rd && bus.alu_sel_rd == bus.dec_rs2) begin
      bus.fwd_b_valid = 1'b1;
      bus.fwd_b_data  = bus.alu_data;
    end else if (bus.write_rd2 && bus.sel_rd2 == bus.dec_rs2) begin
      bus.fwd_b_valid = 1'b1;
      bus.fwd_b_data  = bus.rd2;
    end
  end

endmodule

// File: tb/tb_nanorv32_rf_wb_ctrl.sv
// Self-checking bench for nanorv32_rf_wb_ctrl: directed scenarios plus randomized traffic
// compared against a queue/array model of the write-back rules.
module tb_nanorv32_rf_wb_ctrl;

  localparam int LQ_DEPTH = 2;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  nanorv32_rf_wb_ctrl_if bus();

  nanorv32_rf_wb_ctrl #(.LQ_DEPTH(LQ_DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  ent_t lq[$];
  bit   pend_m[32];

  logic        exp_write_rd, exp_write_rd2, exp_lsu_ready, exp_stall;
  logic [4:0]  exp_sel_rd2;
  logic [31:0] exp_rd2;
  logic        exp_fa_v, exp_fb_v;
  logic [31:0] exp_fa_d, exp_fb_d;

  function automatic bit wr_ok(logic [4:0] r);
    return (r != 5'd0) || bus.allow_hidden_use_of_x0;
  endfunction

  function automatic bit busy(logic [4:0] r);
    return wr_ok(r) && pend_m[r];
  endfunction

  task automatic idle_inputs();
    bus.allow_hidden_use_of_x0 = 1'b0;
    bus.alu_valid = 1'b0; bus.alu_sel_rd = '0; bus.alu_data = '0;
    bus.lsu_valid = 1'b0; bus.lsu_sel_rd = '0; bus.lsu_data = '0;
    bus.ld_issue_valid = 1'b0; bus.ld_issue_rd = '0;
    bus.dec_valid = 1'b0; bus.dec_rs1 = '0; bus.dec_rs2 = '0; bus.dec_rd = '0;
  endtask

  // Expected outputs for the current inputs and model state
  task automatic predict();
    exp_write_rd  = bus.alu_valid && wr_ok(bus.alu_sel_rd);
    exp_lsu_ready = (lq.size() < LQ_DEPTH);
    if (lq.size() > 0) begin
      exp_sel_rd2   = lq[0].rd;
      exp_rd2       = lq[0].data;
      exp_write_rd2 = !(exp_write_rd && bus.alu_sel_rd == lq[0].rd);
    end else begin
      exp_sel_rd2   = '0;
      exp_rd2       = '0;
      exp_write_rd2 = 1'b0;
    end
    exp_stall = bus.dec_valid && (busy(bus.dec_rs1) || busy(bus.dec_rs2) || busy(bus.dec_rd));
    exp_fa_v = 1'b0; exp_fa_d = '0; exp_fb_v = 1'b0; exp_fb_d = '0;
    if (exp_write_rd && bus.alu_sel_rd == bus.dec_rs1) begin
      exp_fa_v = 1'b1; exp_fa_d = bus.alu_data;
    end else if (exp_write_rd2 && exp_sel_rd2 == bus.dec_rs1) begin
      exp_fa_v = 1'b1; exp_fa_d = exp_rd2;
    end
    if (exp_write_rd && bus.alu_sel_rd == bus.dec_rs2) begin
      exp_fb_v = 1'b1; exp_fb_d = bus.alu_data;
    end else if (exp_write_rd2 && exp_sel_rd2 == bus.dec_rs2) begin
      exp_fb_v = 1'b1; exp_fb_d = exp_rd2;
    end
  endtask

  task automatic advance();
    ent_t e;
    predict();
    if (exp_write_rd2) begin
      pend_m[lq[0].rd] = 1'b0;
      lq.delete(0);
    end
    if (bus.ld_issue_valid && wr_ok(bus.ld_issue_rd))
      pend_m[bus.ld_issue_rd] = 1'b1;
    if (bus.lsu_valid && exp_lsu_ready && wr_ok(bus.lsu_sel_rd)) begin
      e.rd = bus.lsu_sel_rd;
      e.data = bus.lsu_data;
      lq.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    lq.delete();
    foreach (pend_m[i]) pend_m[i] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    bus.dec_valid = 1'b1; bus.dec_rs1 = 5'd3; bus.dec_rs2 = 5'd9; bus.dec_rd = 5'd1;
    #2;
    checks++; if (bus.write_rd2 !== 1'b0) begin failures++; $display("[TB] FAIL reset_write_rd2 got=%0h want=0", bus.write_rd2); end
    checks++; if (bus.sel_rd2 !== 5'd0) begin failures++; $display("[TB] FAIL reset_sel_rd2 got=%0h want=0", bus.sel_rd2); end
    checks++; if (bus.rd2 !== 32'd0) begin failures++; $display("[TB] FAIL reset_rd2 got=%0h want=0", bus.rd2); end
    checks++; if (bus.lsu_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_lsu_ready got=%0h want=1", bus.lsu_ready); end
    checks++; if (bus.dec_stall !== 1'b0) begin failures++; $display("[TB] FAIL reset_dec_stall got=%0h want=0", bus.dec_stall); end
    advance();
  endtask

  task automatic test_alu_write();
    idle_inputs();
    bus.alu_valid = 1'b1; bus.alu_sel_rd = 5'd5; bus.alu_data = 32'h1234;
    #2;
    checks++; if (bus.write_rd !== 1'b1) begin failures++; $display("[TB] FAIL alu_write_rd got=%0h want=1", bus.write_rd); end
    checks++; if (bus.sel_rd !== 5'd5) begin failures++; $display("[TB] FAIL alu_sel_rd got=%0h want=5", bus.sel_rd); end
    checks++; if (bus.rd !== 32'h1234) begin failures++; $display("[TB] FAIL alu_rd got=%0h want=1234", bus.rd); end
    checks++; if (bus.write_rd2 !== 1'b0) begin failures++; $display("[TB] FAIL alu_write_rd2 got=%0h want=0", bus.write_rd2); end
    advance();
    bus.alu_sel_rd = 5'd0;
    #2;
    checks++; if (bus.write_rd !== 1'b0) begin failures++; $display("[TB] FAIL alu_x0_write_rd got=%0h want=0", bus.write_rd); end
    advance();
  endtask

  task automatic test_load_stall();
    idle_inputs();
    bus.ld_issue_valid = 1'b1; bus.ld_issue_rd = 5'd10;
    #2; advance();
    idle_inputs();
    bus.dec_valid = 1'b1; bus.dec_rs1 = 5'd10;
    bus.lsu_valid = 1'b1; bus.lsu_sel_rd = 5'd10; bus.lsu_data = 32'hCAFEBABE;
    #2;
    checks++; if (bus.dec_stall !== 1'b1) begin failures++; $display("[TB] FAIL ld_stall_pending got=%0h want=1", bus.dec_stall); end
    checks++; if (bus.lsu_ready !== 1'b1) begin failures++; $display("[TB] FAIL ld_lsu_ready got=%0h want=1", bus.lsu_ready); end
    advance();
    idle_inputs();
    bus.dec_valid = 1'b1; bus.dec_rs1 = 5'd10;
    #2;
    checks++; if (bus.write_rd2 !== 1'b1) begin failures++; $display("[TB] FAIL ld_write_rd2 got=%0h want=1", bus.write_rd2); end
    checks++; if (bus.sel_rd2 !== 5'd10) begin failures++; $display("[TB] FAIL ld_sel_rd2 got=%0h want=a", bus.sel_rd2); end
    checks++; if (bus.fwd_a_valid !== 1'b1) begin failures++; $display("[TB] FAIL ld_fwd_a_valid got=%0h want=1", bus.fwd_a_valid); end
    checks++; if (bus.fwd_a_data !== 32'hCAFEBABE) begin failures++; $display("[TB] FAIL ld_fwd_a_data got=%0h want=cafebabe", bus.fwd_a_data); end
    checks++; if (bus.dec_stall !== 1'b1) begin failures++; $display("[TB] FAIL ld_stall_at_write got=%0h want=1", bus.dec_stall); end
    advance();
    bus.dec_valid = 1'b1; bus.dec_rs1 = 5'd10;
    #2;
    checks++; if (bus.dec_stall !== 1'b0) begin failures++; $display("[TB] FAIL ld_stall_cleared got=%0h want=0", bus.dec_stall); end
    advance();
  endtask

  task automatic test_collision();
    idle_inputs();
    bus.lsu_valid = 1'b1; bus.lsu_sel_rd = 5'd3; bus.lsu_data = 32'h11111111;
    #2; advance();
    bus.lsu_sel_rd = 5'd4; bus.lsu_data = 32'h22222222;
    bus.alu_valid = 1'b1; bus.alu_sel_rd = 5'd3; bus.alu_data = 32'hAAAA;
    #2;
    checks++; if (bus.write_rd2 !== 1'b0) begin failures++; $display("[TB] FAIL col_hold1 got=%0h want=0", bus.write_rd2); end
    advance();
    bus.lsu_sel_rd = 5'd6; bus.lsu_data = 32'h33333333;
    #2;
    checks++; if (bus.lsu_ready !== 1'b0) begin failures++; $display("[TB] FAIL col_full_ready got=%0h want=0", bus.lsu_ready); end
    checks++; if (bus.write_rd2 !== 1'b0) begin failures++; $display("[TB] FAIL col_hold2 got=%0h want=0", bus.write_rd2); end
    checks++; if (bus.sel_rd2 !== 5'd3) begin failures++; $display("[TB] FAIL col_head got=%0h want=3", bus.sel_rd2); end
    advance();
    idle_inputs();
    #2;
    checks++; if (bus.write_rd2 !== 1'b1 || bus.sel_rd2 !== 5'd3 || bus.rd2 !== 32'h11111111) begin
      failures++; $display("[TB] FAIL col_drain1 got=%0h/%0h/%0h want=1/3/11111111", bus.write_rd2, bus.sel_rd2, bus.rd2); end
    advance();
    #2;
    checks++; if (bus.write_rd2 !== 1'b1 || bus.sel_rd2 !== 5'd4 || bus.rd2 !== 32'h22222222) begin
      failures++; $display("[TB] FAIL col_drain2 got=%0h/%0h/%0h want=1/4/22222222", bus.write_rd2, bus.sel_rd2, bus.rd2); end
    advance();
    #2;
    checks++; if (bus.write_rd2 !== 1'b0 || bus.lsu_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL col_empty got=%0h/%0h want=0/1", bus.write_rd2, bus.lsu_ready); end
    advance();
  endtask

  task automatic test_x0();
    idle_inputs();
    bus.lsu_valid = 1'b1; bus.lsu_sel_rd = 5'd0; bus.lsu_data = 32'h5A5A;
    bus.ld_issue_valid = 1'b1; bus.ld_issue_rd = 5'd0;
    #2;
    checks++; if (bus.lsu_ready !== 1'b1) begin failures++; $display("[TB] FAIL x0_accept got=%0h want=1", bus.lsu_ready); end
    advance();
    idle_inputs();
    bus.dec_valid = 1'b1;
    #2;
    checks++; if (bus.write_rd2 !== 1'b0) begin failures++; $display("[TB] FAIL x0_dropped got=%0h want=0", bus.write_rd2); end
    checks++; if (bus.dec_stall !== 1'b0) begin failures++; $display("[TB] FAIL x0_no_pend got=%0h want=0", bus.dec_stall); end
    advance();
    idle_inputs();
    bus.allow_hidden_use_of_x0 = 1'b1;
    bus.lsu_valid = 1'b1; bus.lsu_sel_rd = 5'd0; bus.lsu_data = 32'hA5A5;
    bus.ld_issue_valid = 1'b1; bus.ld_issue_rd = 5'd0;
    #2; advance();
    idle_inputs();
    bus.allow_hidden_use_of_x0 = 1'b1;
    bus.dec_valid = 1'b1;
    #2;
    checks++; if (bus.write_rd2 !== 1'b1 || bus.sel_rd2 !== 5'd0 || bus.rd2 !== 32'hA5A5) begin
      failures++; $display("[TB] FAIL x0_hidden_write got=%0h/%0h/%0h want=1/0/a5a5", bus.write_rd2, bus.sel_rd2, bus.rd2); end
    checks++; if (bus.dec_stall !== 1'b1) begin failures++; $display("[TB] FAIL x0_hidden_stall got=%0h want=1", bus.dec_stall); end
    advance();
    #2;
    checks++; if (bus.dec_stall !== 1'b0) begin failures++; $display("[TB] FAIL x0_hidden_clear got=%0h want=0", bus.dec_stall); end
    advance();
  endtask

  task automatic test_set_wins();
    idle_inputs();
    bus.ld_issue_valid = 1'b1; bus.ld_issue_rd = 5'd7;
    bus.lsu_valid = 1'b1; bus.lsu_sel_rd = 5'd7; bus.lsu_data = 32'h77;
    #2; advance();
    idle_inputs();
    bus.ld_issue_valid = 1'b1; bus.ld_issue_rd = 5'd7;
    #2;
    checks++; if (bus.write_rd2 !== 1'b1 || bus.sel_rd2 !== 5'd7) begin
      failures++; $display("[TB] FAIL setwin_head got=%0h/%0h want=1/7", bus.write_rd2, bus.sel_rd2); end
    advance();
    idle_inputs();
    bus.dec_valid = 1'b1; bus.dec_rs2 = 5'd7;
    #2;
    checks++; if (bus.dec_stall !== 1'b1) begin failures++; $display("[TB] FAIL setwin_pend got=%0h want=1", bus.dec_stall); end
    advance();
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    bus.lsu_valid = 1'b1; bus.lsu_sel_rd = 5'd1; bus.lsu_data = 32'h101;
    #2; advance();
    bus.lsu_sel_rd = 5'd2; bus.lsu_data = 32'h202;
    bus.alu_valid = 1'b1; bus.alu_sel_rd = 5'd1; bus.alu_data = 32'h1;
    bus.ld_issue_valid = 1'b1; bus.ld_issue_rd = 5'd9;
    #2; advance();
    idle_inputs();
    bus.alu_valid = 1'b1; bus.alu_sel_rd = 5'd1;
    bus.dec_valid = 1'b1; bus.dec_rs1 = 5'd9;
    #2;
    checks++; if (bus.lsu_ready !== 1'b0) begin failures++; $display("[TB] FAIL rmid_full got=%0h want=0", bus.lsu_ready); end
    checks++; if (bus.dec_stall !== 1'b1) begin failures++; $display("[TB] FAIL rmid_pend got=%0h want=1", bus.dec_stall); end
    rst = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_inputs();
    bus.dec_valid = 1'b1; bus.dec_rs1 = 5'd9; bus.dec_rs2 = 5'd7;
    #2;
    checks++; if (bus.write_rd2 !== 1'b0) begin failures++; $display("[TB] FAIL rmid_write_rd2 got=%0h want=0", bus.write_rd2); end
    checks++; if (bus.lsu_ready !== 1'b1) begin failures++; $display("[TB] FAIL rmid_lsu_ready got=%0h want=1", bus.lsu_ready); end
    checks++; if (bus.dec_stall !== 1'b0) begin failures++; $display("[TB] FAIL rmid_dec_stall got=%0h want=0", bus.dec_stall); end
    advance();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.allow_hidden_use_of_x0 = ($urandom_range(0, 9) == 0);
      bus.alu_valid      = $urandom_range(0, 1);
      bus.alu_sel_rd     = 5'($urandom_range(0, 7));
      bus.alu_data       = $urandom;
      bus.lsu_valid      = ($urandom_range(0, 9) < 6);
      bus.lsu_sel_rd     = 5'($urandom_range(0, 7));
      bus.lsu_data       = $urandom;
      bus.ld_issue_valid = ($urandom_range(0, 9) < 4);
      bus.ld_issue_rd    = 5'($urandom_range(0, 7));
      bus.dec_valid      = $urandom_range(0, 1);
      bus.dec_rs1        = 5'($urandom_range(0, 7));
      bus.dec_rs2        = 5'($urandom_range(0, 7));
      bus.dec_rd         = 5'($urandom_range(0, 7));
      #2;
      predict();
      checks++; if (bus.write_rd !== exp_write_rd) begin failures++; $display("[TB] FAIL rnd_write_rd cyc=%0d got=%0h want=%0h", i, bus.write_rd, exp_write_rd); end
      checks++; if (bus.sel_rd !== bus.alu_sel_rd || bus.rd !== bus.alu_data) begin failures++; $display("[TB] FAIL rnd_port1 cyc=%0d got=%0h/%0h want=%0h/%0h", i, bus.sel_rd, bus.rd, bus.alu_sel_rd, bus.alu_data); end
      checks++; if (bus.lsu_ready !== exp_lsu_ready) begin failures++; $display("[TB] FAIL rnd_lsu_ready cyc=%0d got=%0h want=%0h", i, bus.lsu_ready, exp_lsu_ready); end
      checks++; if (bus.write_rd2 !== exp_write_rd2) begin failures++; $display("[TB] FAIL rnd_write_rd2 cyc=%0d got=%0h want=%0h", i, bus.write_rd2, exp_write_rd2); end
      checks++; if (bus.sel_rd2 !== exp_sel_rd2) begin failures++; $display("[TB] FAIL rnd_sel_rd2 cyc=%0d got=%0h want=%0h", i, bus.sel_rd2, exp_sel_rd2); end
      checks++; if (bus.rd2 !== exp_rd2) begin failures++; $display("[TB] FAIL rnd_rd2 cyc=%0d got=%0h want=%0h", i, bus.rd2, exp_rd2); end
      checks++; if (bus.dec_stall !== exp_stall) begin failures++; $display("[TB] FAIL rnd_dec_stall cyc=%0d got=%0h want=%0h", i, bus.dec_stall, exp_stall); end
      checks++; if (bus.fwd_a_valid !== exp_fa_v || bus.fwd_a_data !== exp_fa_d) begin failures++; $display("[TB] FAIL rnd_fwd_a cyc=%0d got=%0h/%0h want=%0h/%0h", i, bus.fwd_a_valid, bus.fwd_a_data, exp_fa_v, exp_fa_d); end
      checks++; if (bus.fwd_b_valid !== exp_fb_v || bus.fwd_b_data !== exp_fb_d) begin failures++; $display("[TB] FAIL rnd_fwd_b cyc=%0d got=%0h/%0h want=%0h/%0h", i, bus.fwd_b_valid, bus.fwd_b_data, exp_fb_v, exp_fb_d); end
      advance();
    end
  endtask

  initial begin
    idle_inputs();
    $display("[TB] starting nanorv32_rf_wb_ctrl bench");
    test_reset();
    test_alu_write();
    test_load_stall();
    test_collision();
    test_x0();
    test_set_wins();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
